// File: rtl/pch_aux_pwr_seq_pkg.sv
// Shared types for the PCH/BMC aux power sequencer: state and fault-code encodings,
// ms counter width and the "delay reached" helper used by the FSM.
package pch_aux_pwr_seq_pkg;

    localparam int MS_CNT_W = 8;

    typedef enum logic [3:0] {
        ST_OFF       = 4'd0,
        ST_P1V8      = 4'd1,
        ST_PVNN      = 4'd2,
        ST_P1V05     = 4'd3,
        ST_RSM_DLY   = 4'd4,
        ST_BMC_DLY   = 4'd5,
        ST_S5        = 4'd6,
        ST_PWROK_DLY = 4'd7,
        ST_S0        = 4'd8,
        ST_FAULT     = 4'd9
    } seq_state_t;

    typedef enum logic [1:0] {
        FC_NONE  = 2'd0,
        FC_P1V8  = 2'd1,
        FC_PVNN  = 2'd2,
        FC_P1V05 = 2'd3
    } fault_code_t;

    // True on the strobe that brings the count to the limit, so a delay of N ms
    // elapses after N strobes: between N-1 and N ms, never less.
    function automatic logic ms_reached(input logic [MS_CNT_W-1:0] count,
                                        input logic                tick,
                                        input logic [MS_CNT_W-1:0] limit);
        return tick && (({1'b0, count} + {{MS_CNT_W{1'b0}}, 1'b1}) == {1'b0, limit});
    endfunction

endpackage

// File: rtl/seq_ms_timer.sv
// Millisecond counter for the aux sequencer: clears on state entry, counts 1 ms
// strobes and saturates at its maximum value.
module seq_ms_timer
    import pch_aux_pwr_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                tick,
    output logic [MS_CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (tick && (count != {MS_CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pch_aux_pwr_seq.sv
// PCH/BMC aux power sequencer: rail enables, RSMRST#/SRST# release, PCH/SYS PWROK.
// Optional macro PCH_SEQ_FAULT_LATCH_EN: fault latches until cleared instead of auto-retrying.
module pch_aux_pwr_seq
    import pch_aux_pwr_seq_pkg::*;
#(
    parameter int TIMEOUT_MS    = 100,
    parameter int RSMRST_DLY_MS = 10,
    parameter int PWROK_DLY_MS  = 1
) (
    input  logic       iClk_2M,
    input  logic       iRst,
    input  logic       i1mSCE,
    input  logic       iEnable,
    input  logic       PWRGD_P1V8_PCH_AUX_PLD,
    input  logic       PWRGD_PVNN_PCH_AUX,
    input  logic       PWRGD_P1V05_PCH_AUX,
    input  logic       FM_SLPS3_PLD_N,
    input  logic       PWRGD_PS_PWROK_PLD_R,
    input  logic       iClrFault,
    output logic       FM_PCH_P1V8_AUX_EN,
    output logic       FM_PVNN_PCH_AUX_EN,
    output logic       FM_P1V05_PCH_AUX_EN,
    output logic       RST_RSMRST_PLD_R_N,
    output logic       RST_SRST_BMC_PLD_R_N,
    output logic       PWRGD_PCH_PWROK_R,
    output logic       PWRGD_SYS_PWROK_R,
    output logic       oFault,
    output logic [1:0] oFaultCode,
    output logic [3:0] oState
);

    localparam logic [MS_CNT_W-1:0] TIMEOUT_LIM = MS_CNT_W'(TIMEOUT_MS);
    localparam logic [MS_CNT_W-1:0] RSMRST_LIM  = MS_CNT_W'(RSMRST_DLY_MS);
    localparam logic [MS_CNT_W-1:0] PWROK_LIM   = MS_CNT_W'(PWROK_DLY_MS);

    seq_state_t          state, next_state;
    fault_code_t         fault_code, next_code, lost_code;
    logic [MS_CNT_W-1:0] ms_count;
    logic                timeout_hit, rsm_hit, pwrok_hit, s0_ok, rail_watch;
    logic                p1v8_en_d, pvnn_en_d, p1v05_en_d, rsmrst_n_d, srst_n_d;
    logic                pch_pwrok_d, sys_pwrok_d, fault_d;
    logic                p1v8_en_q, pvnn_en_q, p1v05_en_q, rsmrst_n_q, srst_n_q;
    logic                pch_pwrok_q, sys_pwrok_q, fault_q;

`ifndef PCH_SEQ_FAULT_LATCH_EN
    logic unused_clr_fault;
    assign unused_clr_fault = iClrFault;
`endif

    seq_ms_timer u_ms_timer (
        .clk   (iClk_2M),
        .rst   (iRst),
        .clr   (next_state != state),
        .tick  (i1mSCE),
        .count (ms_count)
    );

    assign timeout_hit = ms_reached(ms_count, i1mSCE, TIMEOUT_LIM);
    assign rsm_hit     = ms_reached(ms_count, i1mSCE, RSMRST_LIM);
    assign pwrok_hit   = ms_reached(ms_count, i1mSCE, PWROK_LIM);
    assign s0_ok       = FM_SLPS3_PLD_N && PWRGD_PS_PWROK_PLD_R;
    assign rail_watch  = state inside {ST_RSM_DLY, ST_BMC_DLY, ST_S5, ST_PWROK_DLY, ST_S0};
    assign lost_code   = !PWRGD_P1V8_PCH_AUX_PLD ? FC_P1V8  :
                         !PWRGD_PVNN_PCH_AUX     ? FC_PVNN  :
                         !PWRGD_P1V05_PCH_AUX    ? FC_P1V05 : FC_NONE;

    always_ff @(posedge iClk_2M) begin
        if (iRst) begin
            state       <= ST_OFF;
            fault_code  <= FC_NONE;
            p1v8_en_q   <= 1'b0;
            pvnn_en_q   <= 1'b0;
            p1v05_en_q  <= 1'b0;
            rsmrst_n_q  <= 1'b0;
            srst_n_q    <= 1'b0;
            pch_pwrok_q <= 1'b0;
            sys_pwrok_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= next_state;
            fault_code  <= next_code;
            p1v8_en_q   <= p1v8_en_d;
            pvnn_en_q   <= pvnn_en_d;
            p1v05_en_q  <= p1v05_en_d;
            rsmrst_n_q  <= rsmrst_n_d;
            srst_n_q    <= srst_n_d;
            pch_pwrok_q <= pch_pwrok_d;
            sys_pwrok_q <= sys_pwrok_d;
            fault_q     <= fault_d;
        end
    end

    // Fault handling outranks everything; iEnable low aborts any live state;
    // a timeout is checked only in the ramp states, rail loss only once all rails are up.
    always_comb begin
        next_state = state;
        next_code  = fault_code;
        if (state == ST_FAULT) begin
`ifdef PCH_SEQ_FAULT_LATCH_EN
            if (iClrFault && !iEnable) begin
                next_state = ST_OFF;
                next_code  = FC_NONE;
            end
`else
            if (timeout_hit) begin
                next_state = ST_OFF;
            end
`endif
        end else if (!iEnable) begin
            next_state = ST_OFF;
        end else if (rail_watch && (lost_code != FC_NONE)) begin
            next_state = ST_FAULT;
            next_code  = lost_code;
        end else begin
            case (state)
                ST_OFF: next_state = ST_P1V8;
                ST_P1V8: begin
                    if (PWRGD_P1V8_PCH_AUX_PLD) begin
                        next_state = ST_PVNN;
                    end else if (timeout_hit) begin
                        next_state = ST_FAULT;
                        next_code  = FC_P1V8;
                    end
                end
                ST_PVNN: begin
                    if (PWRGD_PVNN_PCH_AUX) begin
                        next_state = ST_P1V05;
                    end else if (timeout_hit) begin
                        next_state = ST_FAULT;
                        next_code  = FC_PVNN;
                    end
                end
                ST_P1V05: begin
                    if (PWRGD_P1V05_PCH_AUX) begin
                        next_state = ST_RSM_DLY;
                    end else if (timeout_hit) begin
                        next_state = ST_FAULT;
                        next_code  = FC_P1V05;
                    end
                end
                ST_RSM_DLY: if (rsm_hit) next_state = ST_BMC_DLY;
                ST_BMC_DLY: if (rsm_hit) next_state = ST_S5;
                ST_S5:      if (s0_ok) next_state = ST_PWROK_DLY;
                ST_PWROK_DLY: begin
                    if (!s0_ok) begin
                        next_state = ST_S5;
                    end else if (pwrok_hit) begin
                        next_state = ST_S0;
                    end
                end
                ST_S0:   if (!s0_ok) next_state = ST_S5;
                default: next_state = ST_OFF;
            endcase
        end
    end

    // Outputs decode the state being entered so they change on the entry edge;
    // SYS_PWROK trails PCH_PWROK by one cycle but drops with it.
    always_comb begin
        p1v8_en_d   = next_state inside {ST_P1V8, ST_PVNN, ST_P1V05, ST_RSM_DLY,
                                         ST_BMC_DLY, ST_S5, ST_PWROK_DLY, ST_S0};
        pvnn_en_d   = next_state inside {ST_PVNN, ST_P1V05, ST_RSM_DLY,
                                         ST_BMC_DLY, ST_S5, ST_PWROK_DLY, ST_S0};
        p1v05_en_d  = next_state inside {ST_P1V05, ST_RSM_DLY,
                                         ST_BMC_DLY, ST_S5, ST_PWROK_DLY, ST_S0};
        rsmrst_n_d  = next_state inside {ST_BMC_DLY, ST_S5, ST_PWROK_DLY, ST_S0};
        srst_n_d    = next_state inside {ST_S5, ST_PWROK_DLY, ST_S0};
        pch_pwrok_d = (next_state == ST_S0);
        sys_pwrok_d = (next_state == ST_S0) && pch_pwrok_q;
        fault_d     = (next_state == ST_FAULT);
    end

    assign FM_PCH_P1V8_AUX_EN   = p1v8_en_q;
    assign FM_PVNN_PCH_AUX_EN   = pvnn_en_q;
    assign FM_P1V05_PCH_AUX_EN  = p1v05_en_q;
    assign RST_RSMRST_PLD_R_N   = rsmrst_n_q;
    assign RST_SRST_BMC_PLD_R_N = srst_n_q;
    assign PWRGD_PCH_PWROK_R    = pch_pwrok_q;
    assign PWRGD_SYS_PWROK_R    = sys_pwrok_q;
    assign oFault               = fault_q;
    assign oFaultCode           = fault_code;
    assign oState               = state;

endmodule

// File: tb/tb_pch_aux_pwr_seq.sv
// Self-checking bench for pch_aux_pwr_seq: vector table, directed corner sequences and
// randomized traffic against a reference model. Honours PCH_SEQ_FAULT_LATCH_EN.
`timescale 1ns/1ps
module tb_pch_aux_pwr_seq;
    import pch_aux_pwr_seq_pkg::*;

    localparam int TIMEOUT_MS    = 100;
    localparam int RSMRST_DLY_MS = 10;
    localparam int PWROK_DLY_MS  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0, strobe = 1'b0, en = 1'b0, slps3 = 1'b0, psok = 1'b0, clr = 1'b0;
    logic [2:0] pg = 3'b000;
    logic       p1v8En, pvnnEn, p1v05En, rsmN, srstN, pchPwrok, sysPwrok, fault;
    logic [1:0] faultCode;
    logic [3:0] stateOut;

    int checks = 0;
    int fails  = 0;

    seq_state_t mPhase   = ST_OFF;
    int         mElapsed = 0;
    logic [1:0] mCode    = 2'd0;
    logic       mSys     = 1'b0;

    typedef struct {
        logic       rst, en;
        logic [2:0] pg;
        logic       slps3, psok, strobe, clr;
        logic [2:0] expEn;
        logic       expRsm, expSrst, expPch, expSys, expFault;
        logic [1:0] expCode;
        seq_state_t expState;
    } vec_t;

    vec_t vecs[12];

    always #250 clk = ~clk;

    pch_aux_pwr_seq #(
        .TIMEOUT_MS    (TIMEOUT_MS),
        .RSMRST_DLY_MS (RSMRST_DLY_MS),
        .PWROK_DLY_MS  (PWROK_DLY_MS)
    ) dut (
        .iClk_2M              (clk),
        .iRst                 (rst),
        .i1mSCE               (strobe),
        .iEnable              (en),
        .PWRGD_P1V8_PCH_AUX_PLD (pg[2]),
        .PWRGD_PVNN_PCH_AUX   (pg[1]),
        .PWRGD_P1V05_PCH_AUX  (pg[0]),
        .FM_SLPS3_PLD_N       (slps3),
        .PWRGD_PS_PWROK_PLD_R (psok),
        .iClrFault            (clr),
        .FM_PCH_P1V8_AUX_EN   (p1v8En),
        .FM_PVNN_PCH_AUX_EN   (pvnnEn),
        .FM_P1V05_PCH_AUX_EN  (p1v05En),
        .RST_RSMRST_PLD_R_N   (rsmN),
        .RST_SRST_BMC_PLD_R_N (srstN),
        .PWRGD_PCH_PWROK_R    (pchPwrok),
        .PWRGD_SYS_PWROK_R    (sysPwrok),
        .oFault               (fault),
        .oFaultCode           (faultCode),
        .oState               (stateOut)
    );

    function automatic logic [13:0] dutVec();
        return {p1v8En, pvnnEn, p1v05En, rsmN, srstN, pchPwrok, sysPwrok, fault, faultCode, stateOut};
    endfunction

    function automatic logic [13:0] modelVec();
        logic [2:0] rails;
        logic       live;
        live     = mPhase inside {ST_RSM_DLY, ST_BMC_DLY, ST_S5, ST_PWROK_DLY, ST_S0};
        rails[2] = live || (mPhase inside {ST_P1V8, ST_PVNN, ST_P1V05});
        rails[1] = live || (mPhase inside {ST_PVNN, ST_P1V05});
        rails[0] = live || (mPhase == ST_P1V05);
        return {rails, live && (mPhase != ST_RSM_DLY),
                mPhase inside {ST_S5, ST_PWROK_DLY, ST_S0},
                mPhase == ST_S0, mSys, mPhase == ST_FAULT, mCode, 4'(mPhase)};
    endfunction

    function automatic logic [13:0] tableVec(input vec_t v);
        return {v.expEn, v.expRsm, v.expSrst, v.expPch, v.expSys, v.expFault, v.expCode, 4'(v.expState)};
    endfunction

    task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s @%0t: actual %b, required %b", name, $time, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s @%0t: actual %b, required %b", name, $time, act, exp);
        end
    endtask

    // Reference model: delays are counted as strobes seen since the phase began.
    task automatic modelStep();
        seq_state_t nxt;
        int         e;
        logic [1:0] lost;
        logic       s0Ok;
        if (rst) begin
            mPhase   = ST_OFF;
            mElapsed = 0;
            mCode    = 2'd0;
            mSys     = 1'b0;
            return;
        end
        e    = mElapsed + (strobe ? 1 : 0);
        s0Ok = slps3 && psok;
        lost = !pg[2] ? 2'd1 : !pg[1] ? 2'd2 : !pg[0] ? 2'd3 : 2'd0;
        nxt  = mPhase;
        if (mPhase == ST_FAULT) begin
`ifdef PCH_SEQ_FAULT_LATCH_EN
            if (clr && !en) begin
                nxt   = ST_OFF;
                mCode = 2'd0;
            end
`else
            if (strobe && e == TIMEOUT_MS) nxt = ST_OFF;
`endif
        end else if (!en) begin
            nxt = ST_OFF;
        end else if ((mPhase inside {ST_RSM_DLY, ST_BMC_DLY, ST_S5, ST_PWROK_DLY, ST_S0}) && lost != 2'd0) begin
            nxt   = ST_FAULT;
            mCode = lost;
        end else begin
            case (mPhase)
                ST_OFF:   nxt = ST_P1V8;
                ST_P1V8:  if (pg[2]) nxt = ST_PVNN;
                          else if (strobe && e == TIMEOUT_MS) begin nxt = ST_FAULT; mCode = 2'd1; end
                ST_PVNN:  if (pg[1]) nxt = ST_P1V05;
                          else if (strobe && e == TIMEOUT_MS) begin nxt = ST_FAULT; mCode = 2'd2; end
                ST_P1V05: if (pg[0]) nxt = ST_RSM_DLY;
                          else if (strobe && e == TIMEOUT_MS) begin nxt = ST_FAULT; mCode = 2'd3; end
                ST_RSM_DLY:   if (strobe && e == RSMRST_DLY_MS) nxt = ST_BMC_DLY;
                ST_BMC_DLY:   if (strobe && e == RSMRST_DLY_MS) nxt = ST_S5;
                ST_S5:        if (s0Ok) nxt = ST_PWROK_DLY;
                ST_PWROK_DLY: if (!s0Ok) nxt = ST_S5;
                              else if (strobe && e == PWROK_DLY_MS) nxt = ST_S0;
                ST_S0:        if (!s0Ok) nxt = ST_S5;
                default:      nxt = ST_OFF;
            endcase
        end
        mSys     = (nxt == ST_S0) && (mPhase == ST_S0);
        mElapsed = (nxt != mPhase) ? 0 : e;
        mPhase   = nxt;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("model", dutVec(), modelVec());
    endtask

    task automatic applyStimulus(input vec_t v);
        rst    = v.rst;
        en     = v.en;
        pg     = v.pg;
        slps3  = v.slps3;
        psok   = v.psok;
        strobe = v.strobe;
        clr    = v.clr;
    endtask

    task automatic runMs(input int n);
        for (int m = 0; m < n; m++) begin
            for (int c = 0; c < 8; c++) begin
                strobe = (c == 7);
                stepCycle();
            end
            strobe = 1'b0;
        end
    endtask

    task automatic doReset();
        rst = 1'b1; en = 1'b0; pg = 3'b000; slps3 = 1'b0; psok = 1'b0; strobe = 1'b0; clr = 1'b0;
        stepCycle();
        rst = 1'b0;
    endtask

    initial begin
        //            rst en  pg      s3   ok   stb  clr  expEn   rsm  srst pch  sys  flt  code   state
        vecs[0]  = '{1'b1,1'b0,3'b000,1'b0,1'b0,1'b0,1'b0, 3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_OFF};
        vecs[1]  = '{1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,1'b0, 3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_OFF};
        vecs[2]  = '{1'b0,1'b1,3'b000,1'b0,1'b0,1'b0,1'b0, 3'b100,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_P1V8};
        vecs[3]  = '{1'b0,1'b1,3'b100,1'b0,1'b0,1'b0,1'b0, 3'b110,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_PVNN};
        vecs[4]  = '{1'b0,1'b1,3'b110,1'b0,1'b0,1'b0,1'b0, 3'b111,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_P1V05};
        vecs[5]  = '{1'b0,1'b1,3'b111,1'b0,1'b0,1'b0,1'b0, 3'b111,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_RSM_DLY};
        vecs[6]  = '{1'b0,1'b1,3'b111,1'b0,1'b0,1'b1,1'b0, 3'b111,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_RSM_DLY};
        vecs[7]  = '{1'b0,1'b0,3'b111,1'b0,1'b0,1'b0,1'b0, 3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_OFF};
        vecs[8]  = '{1'b0,1'b1,3'b111,1'b0,1'b0,1'b0,1'b0, 3'b100,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_P1V8};
        vecs[9]  = '{1'b0,1'b1,3'b111,1'b0,1'b0,1'b0,1'b0, 3'b110,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_PVNN};
        vecs[10] = '{1'b1,1'b1,3'b111,1'b0,1'b0,1'b0,1'b0, 3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_OFF};
        vecs[11] = '{1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,1'b0, 3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0, ST_OFF};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput($sformatf("vec%0d", i), dutVec(), tableVec(vecs[i]));
        end

        $display("[TB] nominal power-up");
        doReset();
        en = 1'b1; psok = 1'b1;
        runMs(2);
        checkOutput("p1v8 enable first", 14'(dutVec() >> 11), 14'(3'b100));
        pg = 3'b100; runMs(2);
        checkOutput("pvnn enable second", 14'(dutVec() >> 11), 14'(3'b110));
        pg = 3'b110; runMs(2);
        checkOutput("p1v05 enable third", 14'(dutVec() >> 11), 14'(3'b111));
        pg = 3'b111; runMs(RSMRST_DLY_MS - 1);
        checkBit("rsmrst held", rsmN, 1'b0);
        runMs(1);
        checkBit("rsmrst released", rsmN, 1'b1);
        checkBit("srst held at rsmrst", srstN, 1'b0);
        runMs(RSMRST_DLY_MS - 1);
        checkBit("srst held", srstN, 1'b0);
        runMs(1);
        checkBit("srst released", srstN, 1'b1);
        slps3 = 1'b1;
        stepCycle();
        checkBit("pch_pwrok waits", pchPwrok, 1'b0);
        runMs(PWROK_DLY_MS);
        checkBit("pch_pwrok set", pchPwrok, 1'b1);
        checkBit("sys_pwrok lags", sysPwrok, 1'b0);
        stepCycle();
        checkBit("sys_pwrok set", sysPwrok, 1'b1);

        $display("[TB] SLP_S3 drop in S0");
        slps3 = 1'b0;
        stepCycle();
        checkOutput("pwroks drop together", {12'd0, pchPwrok, sysPwrok}, 14'd0);
        checkOutput("resets stay released", {12'd0, rsmN, srstN}, 14'd3);
        slps3 = 1'b1;
        stepCycle();
        runMs(PWROK_DLY_MS);
        checkBit("pch_pwrok repeats", pchPwrok, 1'b1);
        stepCycle();
        checkBit("sys_pwrok repeats", sysPwrok, 1'b1);

        $display("[TB] P1V05 loss in S0");
        pg = 3'b110;
        stepCycle();
        checkOutput("rail loss outputs", 14'(dutVec() >> 6), 14'd1);
        checkOutput("rail loss code", 14'(faultCode), 14'd3);

`ifdef PCH_SEQ_FAULT_LATCH_EN
        clr = 1'b1;
        runMs(TIMEOUT_MS + 1);
        checkBit("fault held with enable", fault, 1'b1);
        en = 1'b0;
        stepCycle();
        checkBit("fault cleared", fault, 1'b0);
        checkOutput("code cleared", 14'(faultCode), 14'd0);
        clr = 1'b0;
`else
        en = 1'b0;
        runMs(TIMEOUT_MS - 1);
        checkBit("fault before retry", fault, 1'b1);
        runMs(1);
        checkBit("fault auto retry", fault, 1'b0);
        checkOutput("code kept after retry", 14'(faultCode), 14'd3);
        checkOutput("state off after retry", 14'(stateOut), 14'(ST_OFF));
`endif

        $display("[TB] PVNN never good");
        doReset();
        en = 1'b1; psok = 1'b1;
        stepCycle();
        pg = 3'b100;
        runMs(TIMEOUT_MS - 1);
        checkBit("no early timeout", fault, 1'b0);
        runMs(1);
        checkBit("pvnn timeout fault", fault, 1'b1);
        checkOutput("pvnn timeout code", 14'(faultCode), 14'd2);
        checkOutput("pvnn timeout enables", 14'(dutVec() >> 11), 14'd0);

        $display("[TB] reset during BMC delay");
        doReset();
        en = 1'b1; psok = 1'b1; pg = 3'b111;
        for (int k = 0; k < 4; k++) stepCycle();
        runMs(RSMRST_DLY_MS + 3);
        checkBit("in bmc delay", rsmN, 1'b1);
        rst = 1'b1;
        stepCycle();
        checkOutput("reset mid sequence", dutVec(), {10'd0, 4'(ST_OFF)});
        rst = 1'b0;

        $display("[TB] randomized traffic");
        doReset();
        en = 1'b1; psok = 1'b1; slps3 = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            rst = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 299) == 0) en = ~en;
            for (int b = 0; b < 3; b++) begin
                if (pg[b]) begin
                    if ($urandom_range(0, 399) == 0) pg[b] = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    pg[b] = 1'b1;
                end
            end
            if ($urandom_range(0, 99) == 0) slps3 = ~slps3;
            if ($urandom_range(0, 149) == 0) psok = ~psok;
            strobe = !strobe && ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 39) == 0);
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
